// File: rtl/acc_job_scheduler.sv
// acc_job_scheduler: shares one accelerator among NREQ requesters.
// Round-robin arbitration, operand latching, start pulse generation,
// result forwarding tagged with the owner id, and a watchdog that
// aborts jobs whose accelerator never reports done.
module acc_job_scheduler #(
    parameter int NREQ         = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 255,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     u_in,
    input  logic [5*NREQ-1:0]     v_in,
    output logic [NREQ-1:0]       grant,
    output logic                  acc_start,
    output logic [1:0]            acc_u,
    output logic [4:0]            acc_v,
    input  logic                  acc_done,
    input  logic                  acc_wr_req,
    input  logic [20:0]           acc_wr_data,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [20:0]           res_data,
    output logic [NREQ-1:0]       job_done,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  win;
    logic [1:0]      win_u;
    logic [4:0]      win_v;
    logic [3:0]      start_cnt;
    logic [9:0]      wd_cnt;
    logic            abort;
    logic            start_last;
    logic            wd_last;
    logic            in_job;

    // First requester at or after p (cyclically) whose bit is set.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] w;
        int             best;
        int             d;
        w    = p;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(p)) % NREQ;
            if (r[i] && (d < best)) begin
                best = d;
                w    = IDW'(i);
            end
        end
        return w;
    endfunction

    assign start_last = (start_cnt == 4'(START_CYCLES - 1));
    assign wd_last    = (wd_cnt == 10'(TIMEOUT - 1));
    assign in_job     = (state == S_START) || (state == S_WAIT) || (state == S_FINISH);

    // Arbitration winner and its operand slices.
    always_comb begin
        win   = rr_pick(req, ptr);
        win_u = '0;
        win_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_u = u_in[2*i +: 2];
                win_v = v_in[5*i +: 5];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs; done in START is ignored,
    // and done on the watchdog's last cycle wins over the abort.
    always_comb begin
        state_nxt   = state;
        acc_start   = 1'b0;
        busy        = (state != S_IDLE);
        job_done    = '0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE:   if (|req) state_nxt = S_ARB;
            S_ARB:    state_nxt = (|req) ? S_START : S_IDLE;
            S_START: begin
                acc_start = 1'b1;
                if (start_last) state_nxt = S_WAIT;
            end
            S_WAIT:   if (acc_done || wd_last) state_nxt = S_FINISH;
            S_FINISH: begin
                job_done    = grant;
                timeout_err = abort;
                state_nxt   = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Start-phase length counter, watchdog counter and abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_cnt <= '0;
            wd_cnt    <= '0;
            abort     <= 1'b0;
        end else begin
            start_cnt <= (state == S_START) ? start_cnt + 4'd1 : 4'd0;
            wd_cnt    <= (state == S_WAIT) ? wd_cnt + 10'd1 : 10'd0;
            if (state == S_WAIT)      abort <= !acc_done && wd_last;
            else if (state == S_IDLE) abort <= 1'b0;
        end
    end

    // Job ownership: latched on ARB exit, released and pointer advanced in FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            acc_u <= '0;
            acc_v <= '0;
        end else if ((state == S_ARB) && (|req)) begin
            owner <= win;
            grant <= NREQ'(1) << win;
            acc_u <= win_u;
            acc_v <= win_v;
        end else if (state == S_FINISH) begin
            grant <= '0;
            acc_u <= '0;
            acc_v <= '0;
            ptr   <= (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
        end
    end

    // Result forwarding: one-cycle registered copy, tagged with the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= acc_wr_req && in_job;
            if (acc_wr_req && in_job) begin
                res_id   <= owner;
                res_data <= acc_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Bench for acc_job_scheduler: job-timeline reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_acc_job_scheduler;
    localparam int NREQ = 4;
    localparam int SC   = 2;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  u_in = 8'b11_01_00_10;
    logic [19:0] v_in = {5'd31, 5'd7, 5'd20, 5'd13};
    logic [3:0]  grant;
    logic        acc_start;
    logic [1:0]  acc_u;
    logic [4:0]  acc_v;
    logic        acc_done = 1'b0;
    logic        acc_wr_req = 1'b0;
    logic [20:0] acc_wr_data = '0;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [20:0] res_data;
    logic [3:0]  job_done;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    acc_job_scheduler #(.NREQ(NREQ), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .u_in(u_in), .v_in(v_in),
        .grant(grant), .acc_start(acc_start), .acc_u(acc_u), .acc_v(acc_v),
        .acc_done(acc_done), .acc_wr_req(acc_wr_req), .acc_wr_data(acc_wr_data),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .job_done(job_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: a job is a timeline indexed by m_t (0 = first granted cycle).
    // Cycles 0..SC-1 pulse start, the wait window follows, and the job ends on
    // cycle m_end, which is fixed once done or the watchdog limit is seen.
    int          m_own = -1;
    bit          m_arb = 1'b0;
    int          m_t = 0;
    int          m_end = -1;
    bit          m_abort = 1'b0;
    int          m_ptr = 0;
    logic [1:0]  m_u = '0;
    logic [4:0]  m_v = '0;
    bit          e_rv = 1'b0;
    logic [1:0]  e_rid = '0;
    logic [20:0] e_rd = '0;

    initial begin
        bit found;
        int idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_own = -1; m_arb = 0; m_t = 0; m_end = -1; m_abort = 0; m_ptr = 0;
                m_u = '0; m_v = '0; e_rv = 0; e_rid = '0; e_rd = '0;
            end else begin
                if (m_own >= 0 && acc_wr_req) begin
                    e_rv = 1; e_rd = acc_wr_data; e_rid = 2'(m_own);
                end else begin
                    e_rv = 0;
                end
                if (m_own >= 0) begin
                    if (m_t == m_end) begin
                        m_ptr = (m_own + 1) % NREQ;
                        m_own = -1; m_end = -1; m_u = '0; m_v = '0;
                    end else begin
                        if (m_t >= SC && m_end < 0) begin
                            if (acc_done) begin
                                m_end = m_t + 1; m_abort = 0;
                            end else if (m_t - SC == TO - 1) begin
                                m_end = m_t + 1; m_abort = 1;
                            end
                        end
                        m_t++;
                    end
                end else if (m_arb) begin
                    m_arb = 0;
                    if (req != 0) begin
                        found = 0;
                        for (int k = 0; k < NREQ; k++) begin
                            idx = (m_ptr + k) % NREQ;
                            if (!found && req[idx[1:0]]) begin
                                found = 1; m_own = idx;
                            end
                        end
                        m_u = 2'(u_in >> (2 * m_own));
                        m_v = 5'(v_in >> (5 * m_own));
                        m_t = 0; m_end = -1; m_abort = 0;
                    end
                end else if (req != 0) begin
                    m_arb = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [31:0] e_g;
        bit          e_fin;
        forever begin
            @(negedge clk);
            e_g   = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
            e_fin = (m_own >= 0) && (m_t == m_end);
            chk("cmp_grant", 32'(grant), e_g);
            chk("cmp_start", 32'(acc_start), 32'((m_own >= 0 && m_t < SC) ? 1 : 0));
            chk("cmp_u", 32'(acc_u), 32'(m_u));
            chk("cmp_v", 32'(acc_v), 32'(m_v));
            chk("cmp_busy", 32'(busy), 32'((m_arb || m_own >= 0) ? 1 : 0));
            chk("cmp_job_done", 32'(job_done), e_fin ? e_g : 32'd0);
            chk("cmp_timeout_err", 32'(timeout_err), 32'(e_fin && m_abort));
            chk("cmp_res_valid", 32'(res_valid), 32'(e_rv));
            chk("cmp_res_id", 32'(res_id), 32'(e_rid));
            chk("cmp_res_data", 32'(res_data), 32'(e_rd));
        end
    end

    // sel: 1 start high, 2 start low, 3 any job_done, 4 any grant.
    task automatic wait_cond(input int sel, input int maxc, output int n);
        bit hit;
        n = 0;
        forever begin
            case (sel)
                1:       hit = acc_start;
                2:       hit = !acc_start;
                3:       hit = (job_done != 0);
                default: hit = (grant != 0);
            endcase
            if (hit) return;
            if (n >= maxc) begin
                checks++; errors++;
                $display("FAIL wait_%0d: no event after %0d cycles", sel, n);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Plays the accelerator for one job: done dly cycles into the wait window.
    task automatic serve(input int dly, output logic [3:0] g, output logic [3:0] jd,
                         output logic te);
        int n;
        wait_cond(1, 40, n);
        g = grant;
        wait_cond(2, 40, n);
        repeat (dly) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        wait_cond(3, 5, n);
        jd = job_done;
        te = timeout_err;
    endtask

    logic [3:0] g;
    logic [3:0] jd;
    logic       te;
    int         n;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);

        // Single job
        req = 4'b0001;
        wait_cond(1, 10, n);
        chk("sj_u", 32'(acc_u), 32'd2);
        chk("sj_v", 32'(acc_v), 32'd13);
        chk("sj_grant", 32'(grant), 32'h1);
        @(negedge clk);
        chk("sj_start_2nd", 32'(acc_start), 32'd1);
        @(negedge clk);
        chk("sj_start_fall", 32'(acc_start), 32'd0);
        repeat (3) @(negedge clk);
        acc_wr_req = 1'b1; acc_wr_data = 21'h12345;
        @(negedge clk);
        acc_wr_req = 1'b0;
        chk("sj_res_valid", 32'(res_valid), 32'd1);
        chk("sj_res_id", 32'(res_id), 32'd0);
        chk("sj_res_data", 32'(res_data), 32'h12345);
        repeat (6) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        chk("sj_job_done", 32'(job_done), 32'h1);
        chk("sj_timeout_err", 32'(timeout_err), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("sj_busy_after", 32'(busy), 32'd0);
        chk("sj_grant_after", 32'(grant), 32'd0);

        // Result strobe while idle is dropped
        acc_wr_req = 1'b1; acc_wr_data = 21'h0AAAA;
        @(negedge clk);
        acc_wr_req = 1'b0;
        chk("idle_wr_valid", 32'(res_valid), 32'd0);
        chk("idle_wr_hold", 32'(res_data), 32'h12345);

        // Reset so the pointer starts at 0, then round-robin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve(k + 1, g, jd, te);
            chk("rr_grant", 32'(g), 32'd1 << k);
            chk("rr_job_done", 32'(jd), 32'd1 << k);
            chk("rr_timeout_err", 32'(te), 32'd0);
            req = req & ~(4'b0001 << k);
            if (k < 3) begin
                @(negedge clk);
                wait_cond(4, 10, n);
                chk("rr_gap_ge2", 32'(n >= 2), 32'd1);
            end
        end

        // Pointer rotation
        @(negedge clk);
        req = 4'b0100;
        serve(2, g, jd, te);
        chk("pr_first", 32'(g), 32'h4);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0101;
        serve(2, g, jd, te);
        chk("pr_wrap", 32'(g), 32'h1);
        req = 4'b0100;
        serve(2, g, jd, te);
        chk("pr_next", 32'(g), 32'h4);
        req = 4'b0000;

        // Watchdog abort
        @(negedge clk);
        req = 4'b1000;
        wait_cond(1, 10, n);
        wait_cond(2, 10, n);
        repeat (TO - 1) @(negedge clk);
        chk("to_not_early", 32'(job_done), 32'd0);
        @(negedge clk);
        chk("to_job_done", 32'(job_done), 32'h8);
        chk("to_timeout_err", 32'(timeout_err), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("to_err_pulse", 32'(timeout_err), 32'd0);
        req = 4'b0010;
        serve(3, g, jd, te);
        chk("to_next_grant", 32'(g), 32'h2);
        chk("to_next_done", 32'(jd), 32'h2);
        chk("to_next_err", 32'(te), 32'd0);
        req = 4'b0000;

        // Burst of results, then done on the watchdog's last cycle
        @(negedge clk);
        req = 4'b0001;
        wait_cond(1, 10, n);
        chk("bd_grant", 32'(grant), 32'h1);
        wait_cond(2, 10, n);
        for (int k = 0; k < 3; k++) begin
            acc_wr_req = 1'b1;
            acc_wr_data = 21'h0A000 + 21'(k);
            @(negedge clk);
            chk("bd_burst_valid", 32'(res_valid), 32'd1);
            chk("bd_burst_data", 32'(res_data), 32'h0A000 + 32'(k));
            chk("bd_burst_id", 32'(res_id), 32'd0);
        end
        acc_wr_req = 1'b0;
        @(negedge clk);
        chk("bd_burst_end", 32'(res_valid), 32'd0);
        repeat (TO - 5) @(negedge clk);
        acc_done = 1'b1; acc_wr_req = 1'b1; acc_wr_data = 21'h1F00F;
        @(negedge clk);
        acc_done = 1'b0; acc_wr_req = 1'b0;
        chk("bd_last_job_done", 32'(job_done), 32'h1);
        chk("bd_last_no_err", 32'(timeout_err), 32'd0);
        chk("bd_last_res_valid", 32'(res_valid), 32'd1);
        chk("bd_last_res_data", 32'(res_data), 32'h1F00F);
        req = 4'b0000;

        // Reset during WAIT
        @(negedge clk);
        req = 4'b1111;
        wait_cond(1, 10, n);
        chk("rm_grant_pre", 32'(grant), 32'h2);
        wait_cond(2, 10, n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_acc_v", 32'(acc_v), 32'd0);
        chk("rm_job_done", 32'(job_done), 32'd0);
        chk("rm_timeout_err", 32'(timeout_err), 32'd0);
        chk("rm_res_data", 32'(res_data), 32'd0);
        serve(2, g, jd, te);
        chk("rm_grant_post", 32'(g), 32'h1);
        chk("rm_done_post", 32'(jd), 32'h1);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
